// File: rtl/eth_frame_packetizer.sv
// MAC-side Avalon-ST to frame-buffer packet stream: tags beats with frame ID and sop/eop,
// truncates over-length frames, drops orphan beats. Output register plus 1-entry skid buffer.
module eth_frame_packetizer #(
  parameter int          AVL_DATA_WIDTH     = 518,
  parameter int          FRAME_ID_WIDTH     = 32,
  parameter int          FRAME_OFFSET_WIDTH = 5,
  parameter logic [3:0]  PORT_ID            = 4'd0,
  parameter int          WIDTH_PKT          = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AVL_DATA_WIDTH-7:0]   eth_data,
  input  logic [5:0]                  eth_empty,
  input  logic                        eth_valid,
  input  logic                        eth_sop,
  input  logic                        eth_eop,
  output logic                        eth_ready,
  output logic [WIDTH_PKT-1:0]        noc_data_in,
  output logic [3:0]                  noc_valid_in,
  output logic [3:0]                  noc_sop_in,
  output logic [3:0]                  noc_eop_in,
  input  logic                        noc_ready_out,
  output logic [15:0]                 frames_sent,
  output logic [15:0]                 frames_truncated,
  output logic [15:0]                 beats_dropped
);

  localparam int DATA_W = AVL_DATA_WIDTH - 6;
  localparam int SEQ_W  = FRAME_ID_WIDTH - 4;
  localparam int SOP_B  = AVL_DATA_WIDTH + 1;
  localparam int EOP_B  = AVL_DATA_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [FRAME_OFFSET_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [FRAME_OFFSET_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [SEQ_W-1:0]              SEQ_ONE = 1;

  logic [1:0]                    state_q, state_d;
  logic [SEQ_W-1:0]              seq_q, seq_d;
  logic [FRAME_OFFSET_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                          rdy_q, rdy_d;
  logic                          skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]             skid_data_q, skid_data_d;
  logic [5:0]                    skid_empty_q, skid_empty_d;
  logic                          skid_sop_q, skid_sop_d;
  logic                          skid_eop_q, skid_eop_d;
  logic                          out_valid_q, out_valid_d;
  logic [WIDTH_PKT-1:0]          out_pkt_q, out_pkt_d;
  logic [15:0]                   sent_q, sent_d;
  logic [15:0]                   trunc_q, trunc_d;
  logic [15:0]                   drop_q, drop_d;

  logic              in_fire, cand_valid, out_free, consume, emit;
  logic [DATA_W-1:0] cand_data, e_data;
  logic [5:0]        cand_empty, e_empty;
  logic              cand_sop, cand_eop, e_sop, e_eop;

  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    beat_cnt_d   = beat_cnt_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_empty_d = skid_empty_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    out_valid_d  = out_valid_q;
    out_pkt_d    = out_pkt_q;
    sent_d       = sent_q;
    trunc_d      = trunc_q;
    drop_d       = drop_q;
    consume      = 1'b0;
    emit         = 1'b0;
    e_sop        = 1'b0;
    e_eop        = 1'b0;
    e_empty      = '0;
    e_data       = '0;

    in_fire    = eth_valid && rdy_q;
    cand_valid = skid_valid_q || in_fire;
    cand_data  = skid_valid_q ? skid_data_q  : eth_data;
    cand_empty = skid_valid_q ? skid_empty_q : eth_empty;
    cand_sop   = skid_valid_q ? skid_sop_q   : eth_sop;
    cand_eop   = skid_valid_q ? skid_eop_q   : eth_eop;
    out_free   = !out_valid_q || noc_ready_out;

    if (out_free) out_valid_d = 1'b0;

    // Beats are only processed when the output register can take a result, so drops also wait.
    if (cand_valid && out_free) begin
      if (state_q == S_PASS) begin
        if (cand_sop) begin
          // Missing eop: close the open frame, leave the sop beat pending for IDLE handling.
          emit    = 1'b1;
          e_eop   = 1'b1;
          sent_d  = sent_q + 16'd1;
          seq_d   = seq_q + SEQ_ONE;
          state_d = S_IDLE;
        end else begin
          consume = 1'b1;
          emit    = 1'b1;
          e_data  = cand_data;
          if (cand_eop) begin
            e_eop   = 1'b1;
            e_empty = cand_empty;
            sent_d  = sent_q + 16'd1;
            seq_d   = seq_q + SEQ_ONE;
            state_d = S_IDLE;
          end else if (beat_cnt_q == CNT_MAX) begin
            e_eop   = 1'b1;
            sent_d  = sent_q + 16'd1;
            trunc_d = trunc_q + 16'd1;
            seq_d   = seq_q + SEQ_ONE;
            state_d = S_DROP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end else begin
        consume = 1'b1;
        if (cand_sop) begin
          emit       = 1'b1;
          e_sop      = 1'b1;
          e_data     = cand_data;
          beat_cnt_d = CNT_ONE;
          if (cand_eop) begin
            e_eop   = 1'b1;
            e_empty = cand_empty;
            sent_d  = sent_q + 16'd1;
            seq_d   = seq_q + SEQ_ONE;
            state_d = S_IDLE;
          end else begin
            state_d = S_PASS;
          end
        end else begin
          drop_d = drop_q + 16'd1;
          if (cand_eop) state_d = S_IDLE;
        end
      end
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_pkt_d   = {PORT_ID, seq_q, e_sop, e_eop, e_empty, e_data};
    end

    if (skid_valid_q) begin
      if (consume) skid_valid_d = 1'b0;
    end else if (in_fire && !consume) begin
      skid_valid_d = 1'b1;
      skid_data_d  = eth_data;
      skid_empty_d = eth_empty;
      skid_sop_d   = eth_sop;
      skid_eop_d   = eth_eop;
    end

    rdy_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      seq_q        <= '0;
      beat_cnt_q   <= '0;
      rdy_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_empty_q <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pkt_q    <= '0;
      sent_q       <= '0;
      trunc_q      <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      beat_cnt_q   <= beat_cnt_d;
      rdy_q        <= rdy_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_empty_q <= skid_empty_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      out_valid_q  <= out_valid_d;
      out_pkt_q    <= out_pkt_d;
      sent_q       <= sent_d;
      trunc_q      <= trunc_d;
      drop_q       <= drop_d;
    end
  end

  assign eth_ready        = rdy_q;
  assign noc_data_in      = out_pkt_q;
  assign noc_valid_in     = {4{out_valid_q}};
  assign noc_sop_in       = {4{out_pkt_q[SOP_B]}};
  assign noc_eop_in       = {4{out_pkt_q[EOP_B]}};
  assign frames_sent      = sent_q;
  assign frames_truncated = trunc_q;
  assign beats_dropped    = drop_q;

endmodule

// File: tb/tb_eth_frame_packetizer.sv
// Directed bench for eth_frame_packetizer (PORT_ID=2) with hand-computed expected packets.
module tb_eth_frame_packetizer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [511:0] eth_data = '0;
  logic [5:0]   eth_empty = '0;
  logic         eth_valid = 1'b0;
  logic         eth_sop = 1'b0;
  logic         eth_eop = 1'b0;
  logic         eth_ready;
  logic [551:0] noc_data_in;
  logic [3:0]   noc_valid_in, noc_sop_in, noc_eop_in;
  logic         noc_ready_out = 1'b1;
  logic [15:0]  frames_sent, frames_truncated, beats_dropped;

  int n_assert = 0;
  int n_fail   = 0;

  eth_frame_packetizer #(.PORT_ID(4'd2)) dut (
    .clk(clk), .rst(rst),
    .eth_data(eth_data), .eth_empty(eth_empty), .eth_valid(eth_valid),
    .eth_sop(eth_sop), .eth_eop(eth_eop), .eth_ready(eth_ready),
    .noc_data_in(noc_data_in), .noc_valid_in(noc_valid_in),
    .noc_sop_in(noc_sop_in), .noc_eop_in(noc_eop_in), .noc_ready_out(noc_ready_out),
    .frames_sent(frames_sent), .frames_truncated(frames_truncated),
    .beats_dropped(beats_dropped)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [551:0] got, input logic [551:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] d(input int n);
    return {16{32'(n)}};
  endfunction

  function automatic logic [551:0] pk(input int seq, input logic sop, input logic eop,
                                      input logic [5:0] emp, input logic [511:0] dat);
    return {4'd2, 28'(seq), sop, eop, emp, dat};
  endfunction

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [5:0] emp, input logic [511:0] dat);
    eth_valid = v; eth_sop = s; eth_eop = e; eth_empty = emp; eth_data = dat;
  endtask

  int  bi, k, n_stall_acc;
  logic nrdy, acc, prev_stall;
  logic [551:0] prev_pkt;

  initial begin
    // Reset state
    #1;
    check("rst_valid", 552'(noc_valid_in), 552'(0));
    check("rst_data", noc_data_in, '0);
    check("rst_ready", 552'(eth_ready), 552'(0));
    check("rst_sent", 552'(frames_sent), 552'(0));
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    check("ready_after_rst", 552'(eth_ready), 552'(1));

    // 3-beat frame, seq 0
    drive(1, 1, 0, 6'd0, d(1)); cyc();
    check("t1_b0", noc_data_in, pk(0, 1, 0, 6'd0, d(1)));
    check("t1_b0_valid", 552'(noc_valid_in), 552'(4'hF));
    check("t1_b0_sop", 552'(noc_sop_in), 552'(4'hF));
    drive(1, 0, 0, 6'd0, d(2)); cyc();
    check("t1_b1", noc_data_in, pk(0, 0, 0, 6'd0, d(2)));
    check("t1_b1_sop", 552'(noc_sop_in), 552'(0));
    drive(1, 0, 1, 6'd5, d(3)); cyc();
    check("t1_b2", noc_data_in, pk(0, 0, 1, 6'd5, d(3)));
    check("t1_b2_eop", 552'(noc_eop_in), 552'(4'hF));
    drive(0, 0, 0, 6'd0, '0); cyc();
    check("t1_idle_valid", 552'(noc_valid_in), 552'(0));
    check("t1_sent", 552'(frames_sent), 552'(1));

    // Single-beat frame, seq 1
    drive(1, 1, 1, 6'd10, d(4)); cyc();
    check("t2_beat", noc_data_in, pk(1, 1, 1, 6'd10, d(4)));
    check("t2_sop", 552'(noc_sop_in), 552'(4'hF));
    check("t2_eop", 552'(noc_eop_in), 552'(4'hF));
    drive(0, 0, 0, 6'd0, '0); cyc();
    check("t2_sent", 552'(frames_sent), 552'(2));

    // 40-beat frame, seq 2: 32 emitted, eop forced on the 32nd, 8 dropped
    for (int i = 0; i < 40; i++) begin
      drive(1, i == 0, i == 39, 6'd7, d(100 + i)); cyc();
      if (i == 0)  check("t3_first", noc_data_in, pk(2, 1, 0, 6'd0, d(100)));
      if (i == 30) check("t3_b30", noc_data_in, pk(2, 0, 0, 6'd0, d(130)));
      if (i == 31) check("t3_trunc_beat", noc_data_in, pk(2, 0, 1, 6'd0, d(131)));
      if (i == 32) check("t3_drop_valid", 552'(noc_valid_in), 552'(0));
    end
    drive(0, 0, 0, 6'd0, '0); cyc();
    check("t3_dropped", 552'(beats_dropped), 552'(8));
    check("t3_truncated", 552'(frames_truncated), 552'(1));
    check("t3_sent", 552'(frames_sent), 552'(3));

    // Backpressure: 8-beat frame, seq 3, noc_ready_out low for 5 cycles
    bi = 0; k = 0; n_stall_acc = 0; prev_stall = 1'b0; prev_pkt = '0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      nrdy = !(c >= 3 && c < 8);
      noc_ready_out = nrdy;
      if (prev_stall) begin
        check("t4_hold_data", noc_data_in, prev_pkt);
        check("t4_hold_valid", 552'(noc_valid_in), 552'(4'hF));
      end
      if (c == 5) check("t4_ready_low", 552'(eth_ready), 552'(0));
      if (noc_valid_in[0] && nrdy) begin
        check("t4_stream", noc_data_in,
              pk(3, k == 0, k == 7, (k == 7) ? 6'd3 : 6'd0, d(200 + k)));
        k++;
      end
      prev_stall = noc_valid_in[0] && !nrdy;
      prev_pkt   = noc_data_in;
      if (bi < 8) drive(1, bi == 0, bi == 7, 6'd3, d(200 + bi));
      else        drive(0, 0, 0, 6'd0, '0);
      acc = eth_valid && eth_ready;
      if (acc && !nrdy) n_stall_acc++;
      cyc();
      if (acc) bi++;
    end
    drive(0, 0, 0, 6'd0, '0);
    noc_ready_out = 1'b1;
    check("t4_count", 552'(k), 552'(8));
    check("t4_stall_accepts", 552'(n_stall_acc), 552'(1));
    cyc();
    check("t4_sent", 552'(frames_sent), 552'(4));
    check("t4_valid_after", 552'(noc_valid_in), 552'(0));

    // Orphans, then a frame missing eop closed out by the next sop frame
    drive(1, 0, 0, 6'd0, d(300)); cyc();
    check("t5_orphan0", 552'(noc_valid_in), 552'(0));
    drive(1, 0, 1, 6'd0, d(301)); cyc();
    check("t5_orphan1", 552'(noc_valid_in), 552'(0));
    check("t5_dropped", 552'(beats_dropped), 552'(10));
    drive(1, 1, 0, 6'd0, d(310)); cyc();
    check("t5_a0", noc_data_in, pk(4, 1, 0, 6'd0, d(310)));
    drive(1, 0, 0, 6'd0, d(311)); cyc();
    check("t5_a1", noc_data_in, pk(4, 0, 0, 6'd0, d(311)));
    drive(1, 1, 0, 6'd0, d(320)); cyc();
    check("t5_closeout", noc_data_in, pk(4, 0, 1, 6'd0, '0));
    check("t5_closeout_eop", 552'(noc_eop_in), 552'(4'hF));
    check("t5_ready_low", 552'(eth_ready), 552'(0));
    drive(1, 0, 1, 6'd9, d(321)); cyc();
    check("t5_b0", noc_data_in, pk(5, 1, 0, 6'd0, d(320)));
    cyc();
    check("t5_b1", noc_data_in, pk(5, 0, 1, 6'd9, d(321)));
    drive(0, 0, 0, 6'd0, '0); cyc();
    check("t5_sent", 552'(frames_sent), 552'(6));

    // Asynchronous reset mid-frame
    drive(1, 1, 0, 6'd0, d(400)); cyc();
    check("t6_c0", noc_data_in, pk(6, 1, 0, 6'd0, d(400)));
    drive(1, 0, 0, 6'd0, d(401));
    #2 rst = 1'b0;
    drive(0, 0, 0, 6'd0, '0);
    #1;
    check("t6_rst_data", noc_data_in, '0);
    check("t6_rst_valid", 552'(noc_valid_in), 552'(0));
    check("t6_rst_ready", 552'(eth_ready), 552'(0));
    check("t6_rst_sent", 552'(frames_sent), 552'(0));
    check("t6_rst_dropped", 552'(beats_dropped), 552'(0));
    check("t6_rst_trunc", 552'(frames_truncated), 552'(0));
    cyc();
    rst = 1'b1;
    cyc();
    drive(1, 0, 0, 6'd0, d(402)); cyc();
    check("t6_cont_valid", 552'(noc_valid_in), 552'(0));
    drive(1, 0, 1, 6'd0, d(403)); cyc();
    drive(0, 0, 0, 6'd0, '0); cyc();
    check("t6_dropped", 552'(beats_dropped), 552'(2));
    check("t6_sent", 552'(frames_sent), 552'(0));
    drive(1, 1, 1, 6'd1, d(404)); cyc();
    check("t6_seq0", noc_data_in, pk(0, 1, 1, 6'd1, d(404)));
    drive(0, 0, 0, 6'd0, '0); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
